// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - serial TDM demultiplexer, four WIDTH-bit channel slots per frame
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in,
    input  logic                 frame,
    input  logic                 enable,
    output logic [4*WIDTH-1:0]   out,
    output logic [3:0]           valid,
    output logic                 frame_done,
    output logic                 sync_err,
    output logic                 locked
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [BW-1:0] FIRST_NEXT = BW'(1);

    typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

    state_t            state;
    logic [BW-1:0]     bit_cnt;
    logic [1:0]        ch_cnt;
    logic [WIDTH-1:0]  shift;

    // In RECV, both counters at zero means the previous frame closed and a frame start is due.
    logic expect_start;
    assign expect_start = (bit_cnt == '0) && (ch_cnt == 2'd0);
    assign locked = (state == RECV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            bit_cnt    <= '0;
            ch_cnt     <= 2'd0;
            shift      <= '0;
            out        <= '0;
            valid      <= 4'b0000;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            valid      <= 4'b0000;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            if (enable) begin
                case (state)
                    HUNT: begin
                        if (frame) begin
                            state   <= RECV;
                            shift   <= {{(WIDTH-1){1'b0}}, in};
                            bit_cnt <= FIRST_NEXT;
                            ch_cnt  <= 2'd0;
                        end
                    end
                    RECV: begin
                        if (expect_start) begin
                            if (frame) begin
                                shift   <= {{(WIDTH-1){1'b0}}, in};
                                bit_cnt <= FIRST_NEXT;
                            end else begin
                                sync_err <= 1'b1;
                                state    <= HUNT;
                            end
                        end else if (frame) begin
                            // Unexpected frame start: drop the partial slot and realign on this bit.
                            sync_err <= 1'b1;
                            shift    <= {{(WIDTH-1){1'b0}}, in};
                            bit_cnt  <= FIRST_NEXT;
                            ch_cnt   <= 2'd0;
                        end else begin
                            shift <= {shift[WIDTH-2:0], in};
                            if (bit_cnt == LAST_BIT) begin
                                out[ch_cnt*WIDTH +: WIDTH] <= {shift[WIDTH-2:0], in};
                                valid      <= 4'b0001 << ch_cnt;
                                frame_done <= (ch_cnt == 2'd3);
                                bit_cnt    <= '0;
                                ch_cnt     <= ch_cnt + 2'd1;
                            end else begin
                                bit_cnt <= bit_cnt + FIRST_NEXT;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - scoreboard bench for tdm_demux4
module tb_tdm_demux4;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in;
    logic        frame;
    logic        enable;
    logic [31:0] out;
    logic [3:0]  valid;
    logic        frame_done;
    logic        sync_err;
    logic        locked;

    tdm_demux4 #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .frame(frame), .enable(enable),
        .out(out), .valid(valid), .frame_done(frame_done),
        .sync_err(sync_err), .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       fd;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   sync_seen = 0;
    int   sync_exp = 0;
    bit   gaps = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (sync_err === 1'b1) sync_seen++;
        if (valid !== 4'b0000 || frame_done !== 1'b0) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", {valid, frame_done}, 5'b0);
            end else begin
                e = q.pop_front();
                chk("valid_mask", valid, 4'b0001 << e.ch);
                chk("slice", out[e.ch*8 +: 8], e.data);
                chk("frame_done", frame_done, e.fd);
                chk("latency", cyc, e.cyc);
            end
        end
    end

    task automatic send_bit(input logic b, input logic f);
        if (gaps) begin
            @(negedge clk);
            enable = 1'b0;
            frame  = 1'b1;
            in     = 1'($urandom);
        end
        @(negedge clk);
        enable = 1'b1;
        in     = b;
        frame  = f;
    endtask

    // Last bit of a slot: the word must appear on the very next edge.
    task automatic send_byte(input logic [7:0] d, input bit f0, input int ch);
        exp_t e;
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i], (i == 7) ? f0 : 1'b0);
            if (i == 0) begin
                e.ch = ch; e.data = d; e.fd = (ch == 3); e.cyc = cyc + 1;
                q.push_back(e);
            end
        end
    endtask

    task automatic send_frame(input logic [31:0] w);
        for (int c = 0; c < 4; c++) send_byte(w[c*8 +: 8], (c == 0), c);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            enable = 1'b0;
            frame  = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in = 1'b0; frame = 1'b0; enable = 1'b0;
        idle(3);
        chk("rst_out", out, 32'h0);
        chk("rst_valid", valid, 4'h0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_sync", {frame_done, sync_err}, 2'b00);
        rst_n = 1'b1;

        // Single frame, then a back-to-back second frame
        send_frame(32'h01FF3CA5);
        idle(2);
        chk("f1_out", out, 32'h01FF3CA5);
        chk("f1_locked", locked, 1'b1);
        send_frame(32'h01FF3CA5);
        send_frame(32'h44332211);
        idle(2);
        chk("f2_out", out, 32'h44332211);
        chk("f2_locked", locked, 1'b1);
        chk("f2_sync", sync_seen, sync_exp);

        // Missing frame start after a completed frame
        do_reset();
        send_frame(32'h01FF3CA5);
        send_bit(1'b1, 1'b0);
        sync_exp++;
        idle(2);
        chk("miss_sync", sync_seen, sync_exp);
        chk("miss_locked", locked, 1'b0);
        chk("miss_out", out, 32'h01FF3CA5);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        idle(2);
        chk("hunt_locked", locked, 1'b0);
        send_frame(32'h44332211);
        idle(2);
        chk("relock_out", out, 32'h44332211);
        chk("relock_locked", locked, 1'b1);

        // Early frame start at bit 12 (mid channel 1)
        send_byte(8'h5A, 1'b1, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        send_frame(32'hDEADBEEF);
        sync_exp++;
        idle(2);
        chk("early_sync", sync_seen, sync_exp);
        chk("early_out", out, 32'hDEADBEEF);

        // Slice 0 must survive a sync error while later slices hold
        send_byte(8'h77, 1'b1, 0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        sync_exp++;
        idle(1);
        chk("hold_out", out, 32'hDEADBE77);
        chk("hold_locked", locked, 1'b1);
        do_reset();

        // Gapped stream with frame toggling on disabled cycles
        gaps = 1;
        send_frame(32'h01FF3CA5);
        gaps = 0;
        idle(2);
        chk("gap_out", out, 32'h01FF3CA5);
        chk("gap_sync", sync_seen, sync_exp);

        // Asynchronous reset mid channel 2
        send_byte(8'h12, 1'b1, 0);
        send_byte(8'h34, 1'b0, 1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", out, 32'h0);
        chk("arst_locked", locked, 1'b0);
        chk("arst_valid", {valid, frame_done, sync_err}, 6'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        idle(2);
        chk("arst_hunt", locked, 1'b0);
        send_frame(32'hC0FFEE42);
        idle(3);
        chk("arst_decode", out, 32'hC0FFEE42);
        chk("final_sync", sync_seen, sync_exp);
        chk("q_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
